// File: rtl/volume_ctrl_if.sv
// Button inputs and step/display outputs shared between the volume front-end and its user.
// The master side drives the raw buttons; the slave side (volume_ctrl) drives the outputs.
interface volume_ctrl_if;
   logic       btn_loud_i;
   logic       btn_quiet_i;
   logic       up_o;
   logic       down_o;
   logic [2:0] atten_o;
   logic       busy_o;

   modport master (
      output btn_loud_i,
      output btn_quiet_i,
      input  up_o,
      input  down_o,
      input  atten_o,
      input  busy_o
   );

   modport slave (
      input  btn_loud_i,
      input  btn_quiet_i,
      output up_o,
      output down_o,
      output atten_o,
      output busy_o
   );
endinterface

// File: rtl/volume_ctrl.sv
// Push-button front-end: sync, debounce, hold-to-repeat and arbitration into 1-cycle up/down steps.
// First step is registered DEBOUNCE_CYCLES+2 cycles after the raw edge; no backpressure, pulses are fire-and-forget.
module volume_ctrl #(
   parameter int DEBOUNCE_CYCLES = 1000,
   parameter int HOLD_CYCLES     = 500000,
   parameter int REPEAT_CYCLES   = 100000,
   parameter int CNT_W           = 20
) (
   input  logic         clk_i,
   input  logic         reset_i,
   volume_ctrl_if.slave bus
);

   typedef enum logic [1:0] {IDLE, DEBNC, HOLD, RPT} state_e;

   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CYCLES - 1);

   state_e           state_q, state_d;
   logic [1:0]       loud_sync_q, loud_sync_d;
   logic [1:0]       quiet_sync_q, quiet_sync_d;
   logic             owner_q, owner_d;   // 1: quiet button owns the FSM
   logic [CNT_W-1:0] timer_q, timer_d;
   logic             up_q, up_d;
   logic             down_q, down_d;
   logic [2:0]       atten_q, atten_d;
   logic             busy_q, busy_d;

   logic             loud, quiet, own_btn, other_btn, step;
   logic [CNT_W-1:0] timer_inc;

   always_comb begin
      loud_sync_d  = {loud_sync_q[0], bus.btn_loud_i};
      quiet_sync_d = {quiet_sync_q[0], bus.btn_quiet_i};
      loud         = loud_sync_q[1];
      quiet        = quiet_sync_q[1];
      own_btn      = owner_q ? quiet : loud;
      other_btn    = owner_q ? loud : quiet;
      timer_inc    = timer_q + CNT_W'(1);

      state_d = state_q;
      owner_d = owner_q;
      timer_d = timer_q;
      step    = 1'b0;

      case (state_q)
         IDLE: begin
            if (loud ^ quiet) begin
               owner_d = quiet;
               timer_d = '0;
               state_d = DEBNC;
            end
         end
         DEBNC: begin
            if (!own_btn || other_btn) begin
               state_d = IDLE;
            end else if (timer_q == DEB_LAST) begin
               step    = 1'b1;
               timer_d = '0;
               state_d = HOLD;
            end else begin
               timer_d = timer_inc;
            end
         end
         HOLD: begin
            if (!own_btn) begin
               state_d = IDLE;
            end else if (timer_q == HOLD_LAST) begin
               step    = 1'b1;
               timer_d = '0;
               state_d = RPT;
            end else begin
               timer_d = timer_inc;
            end
         end
         RPT: begin
            if (!own_btn) begin
               state_d = IDLE;
            end else if (timer_q == RPT_LAST) begin
               step    = 1'b1;
               timer_d = '0;
            end else begin
               timer_d = timer_inc;
            end
         end
         default: state_d = IDLE;
      endcase

      // Steps at the attenuator limits are dropped so the mirror never diverges.
      up_d   = step & owner_q & (atten_q != 3'd7);
      down_d = step & ~owner_q & (atten_q != 3'd1);

      atten_d = atten_q;
      if (up_d) begin
         atten_d = atten_q + 3'd1;
      end else if (down_d) begin
         atten_d = atten_q - 3'd1;
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q      <= IDLE;
         loud_sync_q  <= 2'b00;
         quiet_sync_q <= 2'b00;
         owner_q      <= 1'b0;
         timer_q      <= '0;
         up_q         <= 1'b0;
         down_q       <= 1'b0;
         atten_q      <= 3'd3;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         loud_sync_q  <= loud_sync_d;
         quiet_sync_q <= quiet_sync_d;
         owner_q      <= owner_d;
         timer_q      <= timer_d;
         up_q         <= up_d;
         down_q       <= down_d;
         atten_q      <= atten_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.up_o    = up_q;
   assign bus.down_o  = down_q;
   assign bus.atten_o = atten_q;
   assign bus.busy_o  = busy_q;

endmodule

// File: tb/tb_volume_ctrl.sv
// Directed bench for volume_ctrl with a pulse scoreboard: expected steps are queued when a button
// is driven and matched against every up/down pulse the DUT emits.
module tb_volume_ctrl;
   localparam int D = 4;
   localparam int H = 10;
   localparam int R = 3;

   typedef struct {
      int       cyc;
      bit       quiet;
      logic [2:0] atten;
   } exp_t;

   logic clk_i   = 1'b0;
   logic reset_i = 1'b1;
   int   cyc     = 0;
   int   checks  = 0;
   int   errors  = 0;
   int   model_atten = 3;
   exp_t exp_q[$];

   volume_ctrl_if bus();

   volume_ctrl #(
      .DEBOUNCE_CYCLES(D),
      .HOLD_CYCLES    (H),
      .REPEAT_CYCLES  (R),
      .CNT_W          (20)
   ) dut (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .bus    (bus.slave)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc++;

   // Queue the steps a press sampled from cycle c0 produces if the FSM still sees it at step edge k <= kmax.
   task automatic push_steps(input bit quiet, input int c0, input int kmax);
      exp_t e;
      int   k;
      k = D + 2;
      while (k <= kmax) begin
         if (quiet && model_atten < 7) begin
            model_atten++;
            e.cyc = c0 + k; e.quiet = 1'b1; e.atten = 3'(model_atten);
            exp_q.push_back(e);
         end else if (!quiet && model_atten > 1) begin
            model_atten--;
            e.cyc = c0 + k; e.quiet = 1'b0; e.atten = 3'(model_atten);
            exp_q.push_back(e);
         end
         k = (k == D + 2) ? k + H : k + R;
      end
   endtask

   task automatic check(input string tag, input int obs, input int expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic press(input bit quiet, input int len);
      push_steps(quiet, cyc + 1, len + 1);
      if (quiet) bus.btn_quiet_i = 1'b1; else bus.btn_loud_i = 1'b1;
      repeat (len) @(negedge clk_i);
      bus.btn_quiet_i = 1'b0;
      bus.btn_loud_i  = 1'b0;
      repeat (8) @(negedge clk_i);
   endtask

   task automatic do_reset();
      reset_i = 1'b1;
      model_atten = 3;
      @(negedge clk_i);
      check("rst_up", int'(bus.up_o), 0);
      check("rst_down", int'(bus.down_o), 0);
      check("rst_atten", int'(bus.atten_o), 3);
      check("rst_busy", int'(bus.busy_o), 0);
      @(negedge clk_i);
      reset_i = 1'b0;
      repeat (2) @(negedge clk_i);
   endtask

   // Scoreboard: every pulse must match the queue head; a head whose cycle passes unmatched is a miss.
   always @(negedge clk_i) begin
      if (bus.up_o || bus.down_o) begin
         checks++;
         assert (!(bus.up_o && bus.down_o)) else begin
            errors++;
            $error("FAIL both_pulses: observed up=%0b down=%0b at cycle %0d", bus.up_o, bus.down_o, cyc);
         end
         checks++;
         assert (exp_q.size() > 0) else begin
            errors++;
            $error("FAIL unexpected_pulse: observed up=%0b down=%0b at cycle %0d expected none", bus.up_o, bus.down_o, cyc);
         end
         if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            assert (cyc === e.cyc) else begin
               errors++;
               $error("FAIL pulse_cycle: observed %0d expected %0d", cyc, e.cyc);
            end
            checks++;
            assert ({bus.up_o, bus.down_o} === {e.quiet, !e.quiet}) else begin
               errors++;
               $error("FAIL pulse_dir: observed up=%0b down=%0b expected up=%0b", bus.up_o, bus.down_o, e.quiet);
            end
            checks++;
            assert (bus.atten_o === e.atten) else begin
               errors++;
               $error("FAIL pulse_atten: observed %0d expected %0d", bus.atten_o, e.atten);
            end
         end
      end else if (exp_q.size() > 0) begin
         checks++;
         assert (exp_q[0].cyc > cyc) else begin
            errors++;
            $error("FAIL missed_pulse: observed none expected pulse at cycle %0d", exp_q[0].cyc);
            void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      int c0;
      bus.btn_loud_i  = 1'b0;
      bus.btn_quiet_i = 1'b0;
      @(negedge clk_i);

      // 1: single quiet press, busy rises once the FSM leaves IDLE
      do_reset();
      push_steps(1'b1, cyc + 1, 7);
      bus.btn_quiet_i = 1'b1;
      repeat (3) @(negedge clk_i);
      check("t1_busy", int'(bus.busy_o), 1);
      repeat (3) @(negedge clk_i);
      bus.btn_quiet_i = 1'b0;
      repeat (8) @(negedge clk_i);
      check("t1_atten", int'(bus.atten_o), 4);
      check("t1_idle", int'(bus.busy_o), 0);

      // 2: bouncing loud, then steady for 6 cycles
      do_reset();
      bus.btn_loud_i = 1'b1; @(negedge clk_i);
      bus.btn_loud_i = 1'b0; @(negedge clk_i);
      bus.btn_loud_i = 1'b1; @(negedge clk_i);
      bus.btn_loud_i = 1'b0; @(negedge clk_i);
      push_steps(1'b0, cyc + 1, 7);
      bus.btn_loud_i = 1'b1;
      repeat (6) @(negedge clk_i);
      bus.btn_loud_i = 1'b0;
      repeat (8) @(negedge clk_i);
      check("t2_atten", int'(bus.atten_o), 2);

      // 3: quiet held 40 cycles, saturating at 7
      do_reset();
      press(1'b1, 40);
      check("t3_atten", int'(bus.atten_o), 7);

      // 4a: both buttons together never claim the FSM
      bus.btn_loud_i  = 1'b1;
      bus.btn_quiet_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_i);
         check("t4_both_busy", int'(bus.busy_o), 0);
      end
      bus.btn_loud_i  = 1'b0;
      bus.btn_quiet_i = 1'b0;
      repeat (6) @(negedge clk_i);

      // 4b/5: loud owns the FSM, quiet added in HOLD is ignored; loud saturates at 1
      push_steps(1'b0, cyc + 1, 31);
      bus.btn_loud_i = 1'b1;
      repeat (10) @(negedge clk_i);
      bus.btn_quiet_i = 1'b1;
      repeat (20) @(negedge clk_i);
      bus.btn_loud_i  = 1'b0;
      bus.btn_quiet_i = 1'b0;
      repeat (8) @(negedge clk_i);
      check("t4_atten", int'(bus.atten_o), 1);
      press(1'b1, 6);
      check("t5_atten", int'(bus.atten_o), 2);

      // 6: async reset mid-repeat with quiet still held
      push_steps(1'b1, cyc + 1, 21);
      bus.btn_quiet_i = 1'b1;
      repeat (21) @(negedge clk_i);
      @(posedge clk_i);
      #2 reset_i = 1'b1;
      model_atten = 3;
      #1;
      check("t6_rst_up", int'(bus.up_o), 0);
      check("t6_rst_down", int'(bus.down_o), 0);
      check("t6_rst_atten", int'(bus.atten_o), 3);
      check("t6_rst_busy", int'(bus.busy_o), 0);
      repeat (2) @(negedge clk_i);
      reset_i = 1'b0;
      c0 = cyc + 1;
      push_steps(1'b1, c0, 7);
      repeat (6) @(negedge clk_i);
      bus.btn_quiet_i = 1'b0;
      repeat (8) @(negedge clk_i);
      check("t6_atten", int'(bus.atten_o), 4);

      check("queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
